// File: rtl/sw_mgnt_pkg.sv
// Shared definitions for the switch management request path: arbiter state
// encoding, bus widths and the default request timeout.
package sw_mgnt_pkg;

   localparam int SYS_ADDR_W         = 8;
   localparam int SYS_DATA_W         = 8;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_BUSY  = 2'd1,
      ARB_GAP   = 2'd2,
      ARB_ABORT = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set bit of req scanning
// upward from last+1 (mod N), plus a flag telling whether any bit was set.
module rr_pick #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] cand;

   // NOTE: every variable written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = '0;
      // Scan farthest-first so the nearest requester after last wins.
      for (int k = N; k >= 1; k--) begin
         cand = IDX_W'((int'(last) + k) % N);
         if (req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/sys_req_arbiter.sv
// Round-robin arbiter sharing the switch_ctrl management request bus between
// NUM_REQ masters. Optional transaction timeout: define SYS_ARB_TIMEOUT_EN.
module sys_req_arbiter
   import sw_mgnt_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int IDX_W          = 1,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                          clk_if,
   input  logic                          rst_if,
   input  logic [NUM_REQ-1:0]            m_req_valid,
   input  logic [NUM_REQ-1:0]            m_req_wr,
   input  logic [SYS_ADDR_W*NUM_REQ-1:0] m_req_addr,
   input  logic [SYS_DATA_W*NUM_REQ-1:0] m_req_data,
   input  logic [NUM_REQ-1:0]            m_req_data_valid,
   output logic [NUM_REQ-1:0]            m_req_ack,
   output logic [SYS_DATA_W-1:0]         m_resp_data,
   output logic [NUM_REQ-1:0]            m_resp_data_valid,
   output logic [NUM_REQ-1:0]            m_req_err,
   output logic [NUM_REQ-1:0]            m_grant,
   output logic                          sys_req_valid,
   output logic                          sys_req_wr,
   output logic [SYS_ADDR_W-1:0]         sys_req_addr,
   output logic [SYS_DATA_W-1:0]         sys_req_data,
   output logic                          sys_req_data_valid,
   input  logic                          sys_req_ack,
   input  logic [SYS_DATA_W-1:0]         sys_resp_data,
   input  logic                          sys_resp_data_valid
);

   arb_state_t       state;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] last;
   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;
   logic             busy;

   logic [SYS_ADDR_W-1:0] addr_arr [NUM_REQ];
   logic [SYS_DATA_W-1:0] data_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g] = m_req_addr[g*SYS_ADDR_W +: SYS_ADDR_W];
      assign data_arr[g] = m_req_data[g*SYS_DATA_W +: SYS_DATA_W];
   end

   rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req  (m_req_valid),
      .last (last),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   assign busy        = (state == ARB_BUSY);
   assign m_resp_data = sys_resp_data;

   // Data strobes and responses only pass while a transaction is live.
   always_comb begin
      sys_req_data       = '0;
      sys_req_data_valid = 1'b0;
      m_req_ack          = '0;
      m_resp_data_valid  = '0;
      if (busy) begin
         sys_req_data                = data_arr[gnt_idx];
         sys_req_data_valid          = m_req_data_valid[gnt_idx];
         m_req_ack[gnt_idx]          = sys_req_ack;
         m_resp_data_valid[gnt_idx]  = sys_resp_data_valid;
      end
   end

`ifdef SYS_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] to_cnt;
   logic             ack_seen;
   logic             timeout_hit;

   // A master dropping valid in the same cycle takes the normal release path.
   assign timeout_hit = busy && m_req_valid[gnt_idx] && !ack_seen && !sys_req_ack &&
                        (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_if) begin
      if (rst_if) begin
         to_cnt    <= '0;
         ack_seen  <= 1'b0;
         m_req_err <= '0;
      end else begin
         m_req_err <= '0;
         if (state == ARB_IDLE) begin
            to_cnt   <= '0;
            ack_seen <= 1'b0;
         end else if (busy) begin
            if (sys_req_ack)
               ack_seen <= 1'b1;
            if (!ack_seen && !sys_req_ack)
               to_cnt <= to_cnt + 1'b1;
            if (timeout_hit)
               m_req_err[gnt_idx] <= 1'b1;
         end
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT_CYCLES > 0);
   assign m_req_err      = '0;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_if) begin
      if (rst_if) begin
         state         <= ARB_IDLE;
         gnt_idx       <= '0;
         last          <= IDX_W'(NUM_REQ - 1);
         m_grant       <= '0;
         sys_req_valid <= 1'b0;
         sys_req_wr    <= 1'b0;
         sys_req_addr  <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_any) begin
                  gnt_idx       <= pick_idx;
                  m_grant       <= NUM_REQ'(1) << pick_idx;
                  sys_req_wr    <= m_req_wr[pick_idx];
                  sys_req_addr  <= addr_arr[pick_idx];
                  sys_req_valid <= 1'b1;
                  state         <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (!m_req_valid[gnt_idx]) begin
                  sys_req_valid <= 1'b0;
                  m_grant       <= '0;
                  last          <= gnt_idx;
                  state         <= ARB_GAP;
               end
`ifdef SYS_ARB_TIMEOUT_EN
               else if (timeout_hit) begin
                  sys_req_valid <= 1'b0;
                  m_grant       <= '0;
                  state         <= ARB_ABORT;
               end
`endif
            end
            ARB_GAP: begin
               state <= ARB_IDLE;
            end
`ifdef SYS_ARB_TIMEOUT_EN
            ARB_ABORT: begin
               if (!m_req_valid[gnt_idx]) begin
                  last  <= gnt_idx;
                  state <= ARB_GAP;
               end
            end
`endif
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule
